zombie_lane_engine: RTL and testbench

Parametrised successor to the fight-zombie game core. It keeps a queue of `DEPTH` zombie lane slots over `LANES` lanes, registers falling-edge button presses, and scores hits or charges misses against a lives budget. Replacement lanes come from a free-running LFSR. It adds a start/game-over state machine and a penalty cooldown. The block sits between the button input synchroniser and the display/score driver.

---
 rtl/zombie_lane_engine.sv | 144 ++++++++++++++
 tb/tb_zombie_lane_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/zombie_lane_engine.sv
// Zombie lane game core: lane queue, button edge detection, hit/miss scoring,
// lives budget, penalty cooldown and a start/game-over state machine.
module zombie_lane_engine #(
  parameter int LANES    = 4,
  parameter int LANE_W   = 2,
  parameter int DEPTH    = 4,
  parameter int COOLDOWN = 9500000,
  parameter int LIVES    = 3,
  parameter int SCORE_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LANES-1:0]          btn,
  input  logic                      start,
  output logic [DEPTH*LANE_W-1:0]   location,
  output logic                      hit,
  output logic                      fail,
  output logic [SCORE_W-1:0]        score,
  output logic [3:0]                lives,
  output logic                      game_over,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam int              LOC_W      = DEPTH * LANE_W;
  localparam int              CNT_W      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COOLDOWN - 1);
  localparam logic [3:0]      LIVES_INIT = 4'(LIVES);

  logic [1:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [15:0]        lfsr_reg;
  logic [LANES-1:0]   s1_reg, s2_reg;
  logic [LOC_W-1:0]   loc_reg, loc_next;
  logic               hit_reg, hit_next;
  logic               fail_reg, fail_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [3:0]         lives_reg, lives_next;

  logic [LOC_W-1:0]   init_loc;
  logic [LANES-1:0]   press;
  logic [LANE_W-1:0]  front;
  logic [LANE_W-1:0]  new_slot;
  logic               is_hit;

  // Starting queue counts down from the highest lane, wrapping when DEPTH > LANES.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
      localparam int SLOT_VAL = (LANES - 1 - gi) & (LANES - 1);
      assign init_loc[gi*LANE_W +: LANE_W] = SLOT_VAL[LANE_W-1:0];
    end
  endgenerate

  assign press    = s2_reg & ~s1_reg;
  assign front    = loc_reg[LANE_W-1:0];
  // Only a single press bit on the front lane counts; any other pattern is a miss.
  assign is_hit   = (press == (LANES'(1) << front));
  assign new_slot = lfsr_reg[LANE_W-1:0] + front;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loc_next   = loc_reg;
    hit_next   = 1'b0;
    fail_next  = 1'b0;
    score_next = score_reg;
    lives_next = lives_reg;
    case (state_reg)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_next = S_PLAY;
          loc_next   = init_loc;
          score_next = '0;
          lives_next = LIVES_INIT;
        end
      end
      S_PLAY: begin
        if (press != '0) begin
          if (is_hit) begin
            hit_next   = 1'b1;
            loc_next   = {new_slot, loc_reg[LOC_W-1:LANE_W]};
            state_next = S_COOL;
            if (score_reg != '1) begin
              score_next = score_reg + SCORE_W'(1);
            end
          end else begin
            fail_next  = 1'b1;
            lives_next = lives_reg - 4'd1;
            state_next = (lives_reg == 4'd1) ? S_OVER : S_COOL;
          end
        end
      end
      S_COOL: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = S_PLAY;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      lfsr_reg  <= 16'hACE1;
      s1_reg    <= '1;
      s2_reg    <= '1;
      loc_reg   <= init_loc;
      hit_reg   <= 1'b0;
      fail_reg  <= 1'b0;
      score_reg <= '0;
      lives_reg <= LIVES_INIT;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lfsr_reg  <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      s1_reg    <= btn;
      s2_reg    <= s1_reg;
      loc_reg   <= loc_next;
      hit_reg   <= hit_next;
      fail_reg  <= fail_next;
      score_reg <= score_next;
      lives_reg <= lives_next;
    end
  end

  assign location  = loc_reg;
  assign hit       = hit_reg;
  assign fail      = fail_reg;
  assign score     = score_reg;
  assign lives     = lives_reg;
  assign game_over = (state_reg == S_OVER);
  assign busy      = (state_reg == S_COOL);

endmodule

// File: tb/tb_zombie_lane_engine.sv
// Bench for zombie_lane_engine: directed vector table plus random play vs a lane-queue model.
module tb_zombie_lane_engine;
  localparam int LANES = 4, LANE_W = 2, DEPTH = 4, COOLDOWN = 4, LIVES = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn   = 4'hF;

  logic [7:0]  location, location2;
  logic        hit, hit2, fail, fail2, game_over, game_over2, busy, busy2;
  logic [15:0] score;
  logic [1:0]  score2;
  logic [3:0]  lives, lives2;

  zombie_lane_engine #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .COOLDOWN(COOLDOWN),
                       .LIVES(LIVES), .SCORE_W(16)) u_dut (
    .clock(clock), .reset(reset), .btn(btn), .start(start), .location(location),
    .hit(hit), .fail(fail), .score(score), .lives(lives), .game_over(game_over), .busy(busy));

  // Narrow-score twin driven by the same stimulus to exercise saturation.
  zombie_lane_engine #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .COOLDOWN(COOLDOWN),
                       .LIVES(LIVES), .SCORE_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .btn(btn), .start(start), .location(location2),
    .hit(hit2), .fail(fail2), .score(score2), .lives(lives2), .game_over(game_over2), .busy(busy2));

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       st;
    logic [3:0] b;
    logic       e_hit, e_fail, e_busy, e_over;
    logic [3:0] e_lives;
    int         e_score;
    logic [7:0] e_loc, loc_mask;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  typedef enum {M_IDLE, M_PLAY, M_COOL, M_OVER} mode_t;
  mode_t      m_mode = M_IDLE;
  int         m_cool = 0;
  int         q[$];
  int         m_score = 0, m_lives = LIVES;
  bit         m_hit = 0, m_fail = 0;
  bit [15:0]  m_lfsr = 16'hACE1;
  bit [3:0]   m_p1 = 4'hF, m_p2 = 4'hF;

  function automatic void add(input logic rst, input logic st, input logic [3:0] b,
                              input logic h, input logic f, input logic bz, input logic ov,
                              input logic [3:0] lv, input int sc, input logic [7:0] loc,
                              input logic [7:0] mask);
    vec_t v;
    v = '{rst, st, b, h, f, bz, ov, lv, sc, loc, mask};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void model_init_queue();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(((LANES - 1 - i) % LANES + LANES) % LANES);
  endfunction

  // Game-level model: lanes as a queue, cooldown as cycles remaining.
  task automatic model_step();
    bit [3:0] press;
    int k;
    m_hit = 0;
    m_fail = 0;
    if (reset) begin
      m_mode = M_IDLE; m_cool = 0; model_init_queue();
      m_score = 0; m_lives = LIVES; m_lfsr = 16'hACE1; m_p1 = 4'hF; m_p2 = 4'hF;
    end else begin
      press = m_p2 & ~m_p1;
      case (m_mode)
        M_IDLE, M_OVER: if (start) begin
          m_mode = M_PLAY; model_init_queue(); m_score = 0; m_lives = LIVES;
        end
        M_PLAY: if (press != 0) begin
          if ($countones(press) == 1 && press[q[0]]) begin
            k = q[0];
            m_hit = 1;
            void'(q.pop_front());
            q.push_back((int'(m_lfsr % LANES) + k) % LANES);
            m_score++;
            m_mode = M_COOL; m_cool = COOLDOWN;
          end else begin
            m_fail = 1;
            m_lives--;
            if (m_lives == 0) m_mode = M_OVER;
            else begin m_mode = M_COOL; m_cool = COOLDOWN; end
          end
        end
        M_COOL: begin
          m_cool--;
          if (m_cool == 0) m_mode = M_PLAY;
        end
        default: ;
      endcase
      m_p2 = m_p1;
      m_p1 = btn;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  endtask

  initial begin
    logic [7:0] exp_loc;
    int hold;
    // Reset, start, hit with cooldown and ignored press, long hold.
    add(1,0,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(1,0,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,1,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'h7, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'h7, 1,0,1,0,2,1,8'h06,8'h3F);
    add(0,0,4'h6, 0,0,1,0,2,1,8'h06,8'h3F);
    add(0,0,4'h7, 0,0,1,0,2,1,8'h06,8'h3F);
    add(0,0,4'h7, 0,0,1,0,2,1,8'h06,8'h3F);
    for (int i = 0; i < 16; i++) add(0,0,4'h7, 0,0,0,0,2,1,8'h06,8'h3F);
    add(0,0,4'hF, 0,0,0,0,2,1,8'h06,8'h3F);
    add(0,0,4'hF, 0,0,0,0,2,1,8'h06,8'h3F);
    // Two misses leading to game over, press ignored while over.
    add(0,0,4'hE, 0,0,0,0,2,1,8'h06,8'h3F);
    add(0,0,4'hF, 0,1,1,0,1,1,8'h06,8'h3F);
    for (int i = 0; i < 3; i++) add(0,0,4'hF, 0,0,1,0,1,1,8'h06,8'h3F);
    add(0,0,4'hF, 0,0,0,0,1,1,8'h06,8'h3F);
    add(0,0,4'hE, 0,0,0,0,1,1,8'h06,8'h3F);
    add(0,0,4'hF, 0,1,0,1,0,1,8'h06,8'h3F);
    add(0,0,4'hF, 0,0,0,1,0,1,8'h06,8'h3F);
    add(0,0,4'hE, 0,0,0,1,0,1,8'h06,8'h3F);
    add(0,0,4'hF, 0,0,0,1,0,1,8'h06,8'h3F);
    // Restart, simultaneous two-lane press is a miss.
    add(0,1,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'h6, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hF, 0,1,1,0,1,0,8'h1B,8'hFF);
    for (int i = 0; i < 3; i++) add(0,0,4'hF, 0,0,1,0,1,0,8'h1B,8'hFF);
    add(0,0,4'hF, 0,0,0,0,1,0,8'h1B,8'hFF);
    // Four hits on lanes 3,2,1,0: narrow score saturates at 3.
    add(0,0,4'h7, 0,0,0,0,1,0,8'h1B,8'hFF);
    add(0,0,4'hF, 1,0,1,0,1,1,8'h06,8'h3F);
    for (int i = 0; i < 3; i++) add(0,0,4'hF, 0,0,1,0,1,1,8'h06,8'h3F);
    add(0,0,4'hF, 0,0,0,0,1,1,8'h06,8'h3F);
    add(0,0,4'hB, 0,0,0,0,1,1,8'h06,8'h3F);
    add(0,0,4'hF, 1,0,1,0,1,2,8'h01,8'h0F);
    for (int i = 0; i < 3; i++) add(0,0,4'hF, 0,0,1,0,1,2,8'h01,8'h0F);
    add(0,0,4'hF, 0,0,0,0,1,2,8'h01,8'h0F);
    add(0,0,4'hD, 0,0,0,0,1,2,8'h01,8'h0F);
    add(0,0,4'hF, 1,0,1,0,1,3,8'h00,8'h03);
    for (int i = 0; i < 3; i++) add(0,0,4'hF, 0,0,1,0,1,3,8'h00,8'h03);
    add(0,0,4'hF, 0,0,0,0,1,3,8'h00,8'h03);
    add(0,0,4'hE, 0,0,0,0,1,3,8'h00,8'h03);
    add(0,0,4'hF, 1,0,1,0,1,4,8'h00,8'h00);
    add(0,0,4'hF, 0,0,1,0,1,4,8'h00,8'h00);
    // Reset mid-cooldown, press in IDLE ignored, press coinciding with start ignored.
    add(1,0,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hE, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hE, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,1,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hF, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'h7, 0,0,0,0,2,0,8'h1B,8'hFF);
    add(0,0,4'hF, 1,0,1,0,2,1,8'h06,8'h3F);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      start = vecs[i].st;
      btn   = vecs[i].b;
      @(posedge clock);
      model_step();
      #1;
      check("hit",    i, hit,       vecs[i].e_hit);
      check("fail",   i, fail,      vecs[i].e_fail);
      check("busy",   i, busy,      vecs[i].e_busy);
      check("over",   i, game_over, vecs[i].e_over);
      check("lives",  i, lives,     vecs[i].e_lives);
      check("score",  i, score,     vecs[i].e_score);
      check("score2", i, score2,    (vecs[i].e_score > 3) ? 3 : vecs[i].e_score);
      check("loc",    i, location & vecs[i].loc_mask, vecs[i].e_loc & vecs[i].loc_mask);
    end

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 9) == 0);
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    btn = 4'hF;
          2:       btn = ~(4'b0001 << q[0]);
          default: btn = 4'($urandom);
        endcase
        hold = $urandom_range(1, 6);
      end else begin
        hold--;
      end
      @(posedge clock);
      model_step();
      #1;
      exp_loc = '0;
      for (int s = 0; s < DEPTH; s++) exp_loc[s*LANE_W +: LANE_W] = 2'(q[s]);
      check("r_loc",    c, location,  exp_loc);
      check("r_hit",    c, hit,       m_hit);
      check("r_fail",   c, fail,      m_fail);
      check("r_score",  c, score,     m_score);
      check("r_score2", c, score2,    (m_score > 3) ? 3 : m_score);
      check("r_lives",  c, lives,     m_lives);
      check("r_over",   c, game_over, m_mode == M_OVER);
      check("r_busy",   c, busy,      m_mode == M_COOL);
      check("r_loc2",   c, location2, exp_loc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
